// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like request/response port: one request channel (req/addr_ok) and an
// in-order response channel (data_ok/rdata). master issues, slave answers.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req;
   logic                  wr;
   logic [1:0]            size;
   logic [DATA_W/8-1:0]   wstrb;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Data wins arbitration; an owner FIFO routes in-order responses back to their issuer.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   mem_bus_arbiter_if.slave             i_bus,
   mem_bus_arbiter_if.slave             d_bus,
   mem_bus_arbiter_if.master            m_bus,
   input  logic                         inst_flush,
   output logic [$clog2(MAX_OUT):0]     out_cnt
);
   localparam int CNT_W = $clog2(MAX_OUT) + 1;
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t             state_reg, state_next;
   logic               owner_reg, owner_next;
   logic               cancel_pend_reg, cancel_pend_next;
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               fifo_owner_reg   [MAX_OUT];
   logic               fifo_discard_reg [MAX_OUT];

   logic               sel;
   logic               grant_req;
   logic               accept;
   logic               full;
   logic               empty;
   logic               push_discard;
   logic               pop;
   logic               head_owner;
   logic               head_drop;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W/8-1:0] sel_wstrb;

   // Fetch never writes, so its store-side fields are intentionally ignored.
   logic unused_fetch_fields;
   assign unused_fetch_fields = &{1'b0, i_bus.wr, i_bus.wstrb, i_bus.wdata};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (cnt_reg == CNT_W'(MAX_OUT));
   assign empty = (cnt_reg == '0);

   always_comb begin
      state_next       = state_reg;
      owner_next       = owner_reg;
      cancel_pend_next = cancel_pend_reg;
      sel              = OWN_INST;
      grant_req        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            sel       = d_bus.req ? OWN_DATA : OWN_INST;
            grant_req = (d_bus.req | i_bus.req) & ~full;
            if (grant_req && !m_bus.addr_ok) begin
               state_next = ST_HOLD;
               owner_next = sel;
            end
         end
         ST_HOLD: begin
            // Arbitration is frozen until the held request is taken.
            sel       = owner_reg;
            grant_req = 1'b1;
            if (m_bus.addr_ok) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      accept = grant_req & m_bus.addr_ok;
      if (accept) begin
         cancel_pend_next = 1'b0;
      end else if (state_reg == ST_HOLD && owner_reg == OWN_INST && inst_flush) begin
         cancel_pend_next = 1'b1;
      end
   end

   assign push_discard = (sel == OWN_INST) & (inst_flush | cancel_pend_reg);
   assign pop          = m_bus.data_ok & ~empty;
   assign head_owner   = fifo_owner_reg[rd_ptr_reg];
   // A flush in the pop cycle also kills the fetch response arriving now.
   assign head_drop    = fifo_discard_reg[rd_ptr_reg] | inst_flush;

   assign sel_addr  = (sel == OWN_DATA) ? d_bus.addr : i_bus.addr;
   assign sel_wstrb = (sel == OWN_DATA) ? d_bus.wstrb : '0;

   assign m_bus.req   = grant_req;
   assign m_bus.wr    = (sel == OWN_DATA) & d_bus.wr;
   assign m_bus.size  = (sel == OWN_DATA) ? d_bus.size : i_bus.size;
   assign m_bus.wstrb = sel_wstrb;
   assign m_bus.addr  = sel_addr;
   assign m_bus.wdata = d_bus.wdata;

   assign i_bus.addr_ok = accept & (sel == OWN_INST);
   assign d_bus.addr_ok = accept & (sel == OWN_DATA);
   assign d_bus.data_ok = pop & (head_owner == OWN_DATA);
   assign i_bus.data_ok = pop & (head_owner == OWN_INST) & ~head_drop;
   assign i_bus.rdata   = m_bus.rdata;
   assign d_bus.rdata   = m_bus.rdata;

   assign out_cnt = cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         owner_reg       <= OWN_DATA;
         cancel_pend_reg <= 1'b0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         cnt_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         owner_reg       <= owner_next;
         cancel_pend_reg <= cancel_pend_next;
         if (accept) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({accept, pop})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   // Per-entry storage so a flush can mark every queued fetch in one cycle.
   for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (reset) begin
            fifo_owner_reg[gi]   <= OWN_DATA;
            fifo_discard_reg[gi] <= 1'b0;
         end else if (accept && wr_ptr_reg == PTR_W'(gi)) begin
            fifo_owner_reg[gi]   <= sel;
            fifo_discard_reg[gi] <= push_discard;
         end else if (inst_flush && fifo_owner_reg[gi] == OWN_INST) begin
            fifo_discard_reg[gi] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run scored against a queue-based model
// of the arbiter's grant, ordering and flush-drop rules.
module tb_mem_bus_arbiter;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MAX_OUT = 2;
   localparam int CNT_W   = $clog2(MAX_OUT) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             inst_flush;
   logic [CNT_W-1:0] out_cnt;
   int               check_cnt = 0;
   int               pass_cnt  = 0;

   mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
   mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
   mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

   mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_bus      (i_bus),
      .d_bus      (d_bus),
      .m_bus      (m_bus),
      .inst_flush (inst_flush),
      .out_cnt    (out_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_bus.req = 1'b0; i_bus.addr = '0; i_bus.size = 2'd2;
      i_bus.wr = 1'b0; i_bus.wstrb = '0; i_bus.wdata = '0;
      d_bus.req = 1'b0; d_bus.addr = '0; d_bus.size = 2'd2;
      d_bus.wr = 1'b0; d_bus.wstrb = '0; d_bus.wdata = '0;
      m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; m_bus.rdata = '0;
      inst_flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick(); tick();
      reset = 1'b0;
      #1;
      check_cnt++; if (out_cnt !== 2'd0) $display("FAIL reset_out_cnt got %0d exp 0", out_cnt); else pass_cnt++;
      check_cnt++; if (m_bus.req !== 1'b0) $display("FAIL reset_m_req got %0b exp 0", m_bus.req); else pass_cnt++;
      check_cnt++;
      if ({i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok} !== 4'b0000)
         $display("FAIL reset_handshakes got %b exp 0000", {i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok});
      else pass_cnt++;
      // Stray response with nothing outstanding is ignored.
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h5555_aaaa;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok} !== 2'b00) $display("FAIL empty_rsp_data_ok got %b exp 00", {i_bus.data_ok, d_bus.data_ok});
      else pass_cnt++;
      tick();
      m_bus.data_ok = 1'b0;
      #1;
      check_cnt++; if (out_cnt !== 2'd0) $display("FAIL empty_rsp_out_cnt got %0d exp 0", out_cnt); else pass_cnt++;
   endtask

   task automatic test_single_fetch();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0000; i_bus.size = 2'd2; m_bus.addr_ok = 1'b1;
      #1;
      check_cnt++; if (m_bus.addr !== 32'h1c00_0000) $display("FAIL single_m_addr got %h exp 1c000000", m_bus.addr); else pass_cnt++;
      check_cnt++;
      if ({m_bus.req, m_bus.wr, m_bus.wstrb} !== 6'b100000) $display("FAIL single_m_ctrl got %b exp 100000", {m_bus.req, m_bus.wr, m_bus.wstrb});
      else pass_cnt++;
      check_cnt++;
      if ({i_bus.addr_ok, d_bus.addr_ok} !== 2'b10) $display("FAIL single_addr_ok got %b exp 10", {i_bus.addr_ok, d_bus.addr_ok});
      else pass_cnt++;
      tick();
      i_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      #1;
      check_cnt++; if (out_cnt !== 2'd1) $display("FAIL single_out_cnt1 got %0d exp 1", out_cnt); else pass_cnt++;
      tick();
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0280_0000;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok} !== 2'b10) $display("FAIL single_data_ok got %b exp 10", {i_bus.data_ok, d_bus.data_ok});
      else pass_cnt++;
      check_cnt++; if (i_bus.rdata !== 32'h0280_0000) $display("FAIL single_rdata got %h exp 02800000", i_bus.rdata); else pass_cnt++;
      $display("single_fetch: addr 1c000000 rdata %h", i_bus.rdata);
      tick();
      m_bus.data_ok = 1'b0;
      #1;
      check_cnt++; if (out_cnt !== 2'd0) $display("FAIL single_out_cnt0 got %0d exp 0", out_cnt); else pass_cnt++;
   endtask

   task automatic test_priority();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0004;
      d_bus.req = 1'b1; d_bus.wr = 1'b1; d_bus.addr = 32'h0000_0100; d_bus.wstrb = 4'hf; d_bus.wdata = 32'hdead_beef;
      m_bus.addr_ok = 1'b1;
      #1;
      check_cnt++;
      if ({m_bus.addr, m_bus.wr, m_bus.wstrb, m_bus.wdata} !== {32'h100, 1'b1, 4'hf, 32'hdead_beef})
         $display("FAIL prio_store_fields got %h/%b/%h/%h exp 100/1/f/deadbeef", m_bus.addr, m_bus.wr, m_bus.wstrb, m_bus.wdata);
      else pass_cnt++;
      check_cnt++;
      if ({i_bus.addr_ok, d_bus.addr_ok} !== 2'b01) $display("FAIL prio_addr_ok0 got %b exp 01", {i_bus.addr_ok, d_bus.addr_ok});
      else pass_cnt++;
      tick();
      d_bus.req = 1'b0;
      #1;
      check_cnt++;
      if ({m_bus.addr, m_bus.wr, m_bus.wstrb} !== {32'h1c00_0004, 1'b0, 4'h0})
         $display("FAIL prio_fetch_fields got %h/%b/%h exp 1c000004/0/0", m_bus.addr, m_bus.wr, m_bus.wstrb);
      else pass_cnt++;
      check_cnt++;
      if ({i_bus.addr_ok, d_bus.addr_ok} !== 2'b10) $display("FAIL prio_addr_ok1 got %b exp 10", {i_bus.addr_ok, d_bus.addr_ok});
      else pass_cnt++;
      tick();
      i_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0;
      #1;
      check_cnt++; if (out_cnt !== 2'd2) $display("FAIL prio_out_cnt got %0d exp 2", out_cnt); else pass_cnt++;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok} !== 2'b01) $display("FAIL prio_rsp0 got %b exp 01", {i_bus.data_ok, d_bus.data_ok});
      else pass_cnt++;
      $display("priority: store 100 acked");
      tick();
      m_bus.rdata = 32'h1234_5678;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok, i_bus.rdata} !== {2'b10, 32'h1234_5678})
         $display("FAIL prio_rsp1 got %b/%h exp 10/12345678", {i_bus.data_ok, d_bus.data_ok}, i_bus.rdata);
      else pass_cnt++;
      $display("priority: fetch 1c000004 rdata %h", i_bus.rdata);
      tick();
      idle_inputs();
   endtask

   task automatic test_hold();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0010;
      #1;
      check_cnt++;
      if ({m_bus.req, m_bus.addr, i_bus.addr_ok} !== {1'b1, 32'h1c00_0010, 1'b0})
         $display("FAIL hold_c0 got %b/%h/%b exp 1/1c000010/0", m_bus.req, m_bus.addr, i_bus.addr_ok);
      else pass_cnt++;
      tick();
      d_bus.req = 1'b1; d_bus.wr = 1'b0; d_bus.addr = 32'h0000_0200;
      for (int c = 1; c < 3; c++) begin
         #1;
         check_cnt++;
         if ({m_bus.req, m_bus.addr, d_bus.addr_ok} !== {1'b1, 32'h1c00_0010, 1'b0})
            $display("FAIL hold_c%0d got %b/%h/%b exp 1/1c000010/0", c, m_bus.req, m_bus.addr, d_bus.addr_ok);
         else pass_cnt++;
         tick();
      end
      m_bus.addr_ok = 1'b1;
      #1;
      check_cnt++;
      if ({m_bus.addr, i_bus.addr_ok, d_bus.addr_ok} !== {32'h1c00_0010, 2'b10})
         $display("FAIL hold_accept got %h/%b exp 1c000010/10", m_bus.addr, {i_bus.addr_ok, d_bus.addr_ok});
      else pass_cnt++;
      tick();
      i_bus.req = 1'b0;
      #1;
      check_cnt++;
      if ({m_bus.addr, i_bus.addr_ok, d_bus.addr_ok} !== {32'h200, 2'b01})
         $display("FAIL hold_data_next got %h/%b exp 200/01", m_bus.addr, {i_bus.addr_ok, d_bus.addr_ok});
      else pass_cnt++;
      tick();
      d_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0011;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok} !== 2'b10) $display("FAIL hold_rsp0 got %b exp 10", {i_bus.data_ok, d_bus.data_ok});
      else pass_cnt++;
      tick();
      m_bus.rdata = 32'h0000_0022;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok, d_bus.rdata} !== {2'b01, 32'h22})
         $display("FAIL hold_rsp1 got %b/%h exp 01/22", {i_bus.data_ok, d_bus.data_ok}, d_bus.rdata);
      else pass_cnt++;
      $display("hold: load 200 rdata %h", d_bus.rdata);
      tick();
      idle_inputs();
      #1;
      check_cnt++; if (out_cnt !== 2'd0) $display("FAIL hold_out_cnt got %0d exp 0", out_cnt); else pass_cnt++;
   endtask

   task automatic test_full();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0020; m_bus.addr_ok = 1'b1;
      tick();
      i_bus.addr = 32'h1c00_0024;
      tick();
      i_bus.addr = 32'h1c00_0028;
      #1;
      check_cnt++;
      if ({m_bus.req, i_bus.addr_ok, out_cnt} !== {2'b00, 2'd2})
         $display("FAIL full_block got %b/%b/%0d exp 0/0/2", m_bus.req, i_bus.addr_ok, out_cnt);
      else pass_cnt++;
      tick();
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0a0a;
      #1;
      check_cnt++;
      if ({m_bus.req, i_bus.data_ok, i_bus.rdata} !== {2'b01, 32'h0a0a})
         $display("FAIL full_pop got %b/%b/%h exp 0/1/a0a", m_bus.req, i_bus.data_ok, i_bus.rdata);
      else pass_cnt++;
      tick();
      m_bus.data_ok = 1'b0;
      #1;
      check_cnt++;
      if ({m_bus.req, m_bus.addr, i_bus.addr_ok, out_cnt} !== {1'b1, 32'h1c00_0028, 1'b1, 2'd1})
         $display("FAIL full_resume got %b/%h/%b/%0d exp 1/1c000028/1/1", m_bus.req, m_bus.addr, i_bus.addr_ok, out_cnt);
      else pass_cnt++;
      $display("full: grant resumed at 1c000028");
      tick();
      i_bus.req = 1'b0; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b1;
      tick(); tick();
      m_bus.data_ok = 1'b0;
      #1;
      check_cnt++; if (out_cnt !== 2'd0) $display("FAIL full_drain got %0d exp 0", out_cnt); else pass_cnt++;
   endtask

   task automatic test_flush_outstanding();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0030; m_bus.addr_ok = 1'b1;
      tick();
      i_bus.addr = 32'h1c00_0034;
      tick();
      i_bus.req = 1'b0; m_bus.addr_ok = 1'b0; inst_flush = 1'b1;
      tick();
      inst_flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_bus.data_ok = 1'b1; m_bus.rdata = 32'haaaa_0000 + k;
         #1;
         check_cnt++;
         if ({i_bus.data_ok, d_bus.data_ok} !== 2'b00) $display("FAIL flush_drop%0d got %b exp 00", k, {i_bus.data_ok, d_bus.data_ok});
         else pass_cnt++;
         tick();
      end
      m_bus.data_ok = 1'b0;
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_8000; m_bus.addr_ok = 1'b1;
      #1;
      check_cnt++;
      if ({m_bus.addr, i_bus.addr_ok, out_cnt} !== {32'h1c00_8000, 1'b1, 2'd0})
         $display("FAIL flush_new_req got %h/%b/%0d exp 1c008000/1/0", m_bus.addr, i_bus.addr_ok, out_cnt);
      else pass_cnt++;
      tick();
      i_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0033;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, i_bus.rdata} !== {1'b1, 32'h33}) $display("FAIL flush_new_rsp got %b/%h exp 1/33", i_bus.data_ok, i_bus.rdata);
      else pass_cnt++;
      $display("flush: fetch 1c008000 rdata %h", i_bus.rdata);
      tick();
      idle_inputs();
   endtask

   task automatic test_flush_hold();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0040;
      tick();
      inst_flush = 1'b1;
      tick();
      inst_flush = 1'b0; m_bus.addr_ok = 1'b1;
      #1;
      check_cnt++; if (i_bus.addr_ok !== 1'b1) $display("FAIL flush_hold_accept got %b exp 1", i_bus.addr_ok); else pass_cnt++;
      tick();
      i_bus.req = 1'b0; m_bus.addr_ok = 1'b0;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0044;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok, out_cnt} !== {2'b00, 2'd1})
         $display("FAIL flush_hold_drop got %b/%0d exp 00/1", {i_bus.data_ok, d_bus.data_ok}, out_cnt);
      else pass_cnt++;
      tick();
      m_bus.data_ok = 1'b0;
      #1;
      check_cnt++; if (out_cnt !== 2'd0) $display("FAIL flush_hold_out_cnt got %0d exp 0", out_cnt); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      i_bus.req = 1'b1; i_bus.addr = 32'h1c00_0050; m_bus.addr_ok = 1'b1;
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0000_0055;
      #1;
      check_cnt++;
      if ({i_bus.data_ok, d_bus.data_ok, out_cnt} !== {2'b00, 2'd0})
         $display("FAIL reset_mid got %b/%0d exp 00/0", {i_bus.data_ok, d_bus.data_ok}, out_cnt);
      else pass_cnt++;
      tick();
      idle_inputs();
   endtask

   typedef struct packed {
      bit owner;    // 1 = data
      bit cancel;
   } txn_t;

   task automatic test_random();
      txn_t       q[$];
      bit         held = 0, held_owner = 0, held_cancel = 0;
      bit         full, e_req, own, acc, resp, e_ido, e_ddo;
      logic [38:0] exp_fields;
      reset = 1'b1; idle_inputs();
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!(held && !held_owner)) begin
            i_bus.req  = 1'($urandom_range(0, 1));
            i_bus.addr = $urandom & 32'hffff_fffc;
            i_bus.size = 2'($urandom_range(0, 2));
         end
         if (!(held && held_owner)) begin
            d_bus.req   = ($urandom_range(0, 2) == 0);
            d_bus.wr    = 1'($urandom_range(0, 1));
            d_bus.size  = 2'($urandom_range(0, 2));
            d_bus.wstrb = 4'($urandom);
            d_bus.addr  = $urandom;
            d_bus.wdata = $urandom;
         end
         if (held) begin
            if (held_owner) d_bus.req = 1'b1; else i_bus.req = 1'b1;
         end
         m_bus.addr_ok = ($urandom_range(0, 9) < 6);
         m_bus.data_ok = ($urandom_range(0, 9) < 5);
         m_bus.rdata   = $urandom;
         inst_flush    = ($urandom_range(0, 11) == 0);
         #1;
         full  = (q.size() == MAX_OUT);
         if (held) begin e_req = 1'b1; own = held_owner; end
         else begin e_req = (i_bus.req | d_bus.req) & ~full; own = d_bus.req; end
         acc   = e_req & m_bus.addr_ok;
         resp  = m_bus.data_ok && (q.size() > 0);
         e_ido = 1'b0; e_ddo = 1'b0;
         if (resp) begin
            if (q[0].owner) e_ddo = 1'b1;
            else if (!(q[0].cancel || inst_flush)) e_ido = 1'b1;
         end
         check_cnt++;
         if ({m_bus.req, i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok, out_cnt}
             !== {e_req, acc & ~own, acc & own, e_ido, e_ddo, CNT_W'(q.size())})
            $display("FAIL rnd_ctrl cyc %0d got %b exp %b", cyc,
                     {m_bus.req, i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok, out_cnt},
                     {e_req, acc & ~own, acc & own, e_ido, e_ddo, CNT_W'(q.size())});
         else pass_cnt++;
         if (e_req) begin
            exp_fields = own ? {d_bus.addr, d_bus.wr, d_bus.size, d_bus.wstrb} : {i_bus.addr, 1'b0, i_bus.size, 4'h0};
            check_cnt++;
            if ({m_bus.addr, m_bus.wr, m_bus.size, m_bus.wstrb} !== exp_fields)
               $display("FAIL rnd_fields cyc %0d got %h exp %h", cyc, {m_bus.addr, m_bus.wr, m_bus.size, m_bus.wstrb}, exp_fields);
            else pass_cnt++;
            if (own && d_bus.wr) begin
               check_cnt++;
               if (m_bus.wdata !== d_bus.wdata) $display("FAIL rnd_wdata cyc %0d got %h exp %h", cyc, m_bus.wdata, d_bus.wdata);
               else pass_cnt++;
            end
         end
         if (e_ido) begin
            check_cnt++;
            if (i_bus.rdata !== m_bus.rdata) $display("FAIL rnd_i_rdata cyc %0d got %h exp %h", cyc, i_bus.rdata, m_bus.rdata);
            else pass_cnt++;
         end
         if (e_ddo) begin
            check_cnt++;
            if (d_bus.rdata !== m_bus.rdata) $display("FAIL rnd_d_rdata cyc %0d got %h exp %h", cyc, d_bus.rdata, m_bus.rdata);
            else pass_cnt++;
         end
         if (inst_flush) begin
            foreach (q[k]) if (!q[k].owner) q[k].cancel = 1'b1;
         end
         if (resp) void'(q.pop_front());
         if (acc) begin
            q.push_back('{owner: own, cancel: !own && (inst_flush || held_cancel)});
            $display("rnd txn cyc %0d: %s addr %h", cyc, own ? "data" : "inst", m_bus.addr);
            held = 1'b0; held_cancel = 1'b0;
         end else if (e_req) begin
            if (!held) begin held = 1'b1; held_owner = own; held_cancel = 1'b0; end
            else if (!own && inst_flush) held_cancel = 1'b1;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_fetch();
      test_priority();
      test_hold();
      test_full();
      test_flush_outstanding();
      test_flush_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter for the CPU's single sram-like memory port.
- Shares the port between instruction fetch (IF) and data access (ME stage load/store, i.e. the data_sram traffic).
- Data has fixed priority; responses return in order.
- Tracks up to MAX_OUT outstanding transactions and routes each data_ok/rdata back to the issuing master.
- Silently drains fetch responses cancelled by an exception or ertn flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUT, 2, max accepted-but-unanswered transactions (power of two, >=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request valid
i_addr  in  ADDR_W  fetch address
i_size  in  2  fetch size (0 byte, 1 half, 2 word)
i_addr_ok  out  1  fetch request accepted this cycle
i_data_ok  out  1  fetch response valid
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request valid
d_wr  in  1  1 = store
d_size  in  2  data size
d_wstrb  in  DATA_W/8  byte strobes
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_addr_ok  out  1  data request accepted
d_data_ok  out  1  data response (load data or store ack)
d_rdata  out  DATA_W  load data
inst_flush  in  1  excp_flush | ertn_flush pulse
m_req  out  1  slave request
m_wr  out  1  slave write
m_size  out  2  slave size
m_wstrb  out  DATA_W/8  slave strobes (0 for fetch)
m_addr  out  ADDR_W  slave address
m_wdata  out  DATA_W  slave write data
m_addr_ok  in  1  slave accepted request
m_data_ok  in  1  slave response valid
m_rdata  in  DATA_W  slave read data
out_cnt  out  $clog2(MAX_OUT)+1  outstanding count (debug/drain status)

Behaviour:
- Reset: state IDLE, FIFO empty, out_cnt 0, m_req 0, all addr_ok/data_ok 0, latched owner = data, cancel_pend 0.
- Owner FIFO: MAX_OUT entries of {owner(1: 0 = inst, 1 = data), discard(1)}.
  - full = (out_cnt == MAX_OUT).
  - Push and pop in the same cycle are legal; count is unchanged.
- State IDLE:
  - sel = d_req ? data : inst.
  - m_req = (d_req | i_req) & ~full.
  - m_* fields are muxed combinationally from sel.
  - Fetch drives m_wr = 0 and m_wstrb = 0.
- IDLE, m_req & ~m_addr_ok: latch sel into owner; go to HOLD.
- HOLD:
  - m_req = 1 and fields come from the latched owner; arbitration is frozen, even if d_req rises while inst is held.
  - Requester must hold its fields stable while waiting; this is not checked.
  - On m_addr_ok, return to IDLE. The next grant is evaluated starting the following cycle.
- Accept (m_req & m_addr_ok):
  - Pulse the matching i_addr_ok/d_addr_ok combinationally in the same cycle.
  - Push {owner, discard}.
  - discard = owner == inst & (inst_flush | cancel_pend).
- Response (m_data_ok with FIFO non-empty):
  - Pop the head.
  - Head data: d_data_ok = 1, d_rdata = m_rdata.
  - Head inst, discard 0: i_data_ok = 1, i_rdata = m_rdata.
  - Head inst, discard 1: neither data_ok asserted; entry consumed.
  - Response path is combinational, 0 added latency.
- m_data_ok with FIFO empty: ignored, no pop, no data_ok (protocol error).
- inst_flush:
  - All inst entries currently in the FIFO get discard = 1; the entry being popped the same cycle is also dropped.
  - If state is HOLD with owner inst, cancel_pend is set. It clears on that request's accept, and that entry is pushed with discard = 1.
  - An IDLE-state fetch granted in the flush cycle is pushed with discard = 1.
  - Data entries are never discarded.
- Full: no new grant. A request already in HOLD still completes; HOLD is only entered when not full.
- Reset mid-transaction: FIFO and state are cleared. Any later m_data_ok finds an empty FIFO and is ignored.
- Latency: request to slave 0 cycles (combinational). Throughput is 1 accept/cycle while not full and the slave accepts.

Test Plan:
- Reset, then i_req=1 addr 0x1c000000, slave addr_ok same cycle, data_ok 2 cycles later with rdata 0x02800000 -> i_addr_ok pulse cycle 0, i_data_ok=1 with rdata 0x02800000, out_cnt 1 then 0.
- i_req and d_req (store 0x100, wstrb 0xF, wdata 0xDEADBEEF) asserted together -> data granted first (m_wr=1, m_wstrb=0xF), fetch granted the next cycle. Responses in order: d_data_ok then i_data_ok.
- Inst held in HOLD (addr_ok low 3 cycles), d_req rises in cycle 1 -> m_addr stays on the fetch until accept; data granted the cycle after.
- MAX_OUT=2, two fetches accepted, no data_ok -> third request sees m_req=0, out_cnt=2. One data_ok -> grant resumes next cycle.
- Two fetches outstanding, inst_flush pulse, then new fetch 0x1c008000 -> first two data_ok produce no i_data_ok; third produces i_data_ok with its rdata.
- inst_flush during inst HOLD, then addr_ok -> entry discarded; its data_ok is dropped and out_cnt returns to 0.
